// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit.
// Generates the per-stage stall vector and the branch flush/redirect consumed by the
// inter-stage registers (if_id, id_ex, ex_mem, mem_wb). Hazard sources are load-use,
// IF fetch misses, MEM busy and EX branch redirects. A redirect raised while MEM is
// stalled is held in pend_tgt_q and issued on the first cycle MEM frees up.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall/flush perf counters;
// otherwise stall_cycles_out and flush_count_out are tied to zero.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low = freeze everything)
//   if_stall_req, mem_stall_req          stall requests from IF / MEM
//   id_rs{1,2}_read, id_rs{1,2}_addr     ID source operands
//   ex_loading_in, ex_rd_addr_in         EX load destination
//   ex_branch_in, ex_target_in           EX redirect request
//   stall[5:0]                           [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
//   branch_flag_out, branch_target_out   flush + redirect pc (target 0 when no flush)
//   stall_cycles_out, flush_count_out    perf counters
module pipe_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_stall_req,
    input  logic              mem_stall_req,
    input  logic              id_rs1_read,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic              id_rs2_read,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              ex_loading_in,
    input  logic [REG_AW-1:0] ex_rd_addr_in,
    input  logic              ex_branch_in,
    input  logic [ADDR_W-1:0] ex_target_in,
    output logic [5:0]        stall,
    output logic              branch_flag_out,
    output logic [ADDR_W-1:0] branch_target_out,
    output logic [CNT_W-1:0]  stall_cycles_out,
    output logic [CNT_W-1:0]  flush_count_out
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StRedir   = 2'd2
    } state_e;

    localparam logic [5:0] StallMem  = 6'b011111;
    localparam logic [5:0] StallLoad = 6'b000111;
    localparam logic [5:0] StallIf   = 6'b000011;
    localparam logic [5:0] StallAll  = 6'b111111;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              load_use;

    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_loading_in && (ex_rd_addr_in != '0) &&
                      ((id_rs1_read && (id_rs1_addr == ex_rd_addr_in)) ||
                       (id_rs2_read && (id_rs2_addr == ex_rd_addr_in)));

    always_comb begin
        stall             = '0;
        branch_flag_out   = 1'b0;
        branch_target_out = '0;
        state_d           = state_q;
        pend_tgt_d        = pend_tgt_q;

        if (!rst_in) begin
            // Outputs stay quiet while in reset; state is cleared by the register.
        end else if (!rdy_in) begin
            stall = StallAll;
        end else begin
            case (state_q)
                // MEM_WAIT with mem busy behaves exactly like RUN's top priority, and once
                // mem frees the cycle is evaluated with RUN priority, so both share logic.
                StRun, StMemWait: begin
                    if (mem_stall_req) begin
                        stall = StallMem;
                        if (ex_branch_in) begin
                            pend_tgt_d = ex_target_in;
                            state_d    = StRedir;
                        end else begin
                            state_d = StMemWait;
                        end
                    end else begin
                        state_d = StRun;
                        if (ex_branch_in) begin
                            branch_flag_out   = 1'b1;
                            branch_target_out = ex_target_in;
                        end else if (load_use) begin
                            stall = StallLoad;
                        end else if (if_stall_req) begin
                            stall = StallIf;
                        end
                    end
                end
                StRedir: begin
                    if (mem_stall_req) begin
                        stall = StallMem;
                        // Oldest EX instruction is still resolving; keep its latest target.
                        if (ex_branch_in) begin
                            pend_tgt_d = ex_target_in;
                        end
                    end else begin
                        branch_flag_out   = 1'b1;
                        branch_target_out = pend_tgt_q;
                        state_d           = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= StRun;
            pend_tgt_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (rdy_in) begin
            if (stall != '0) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch_flag_out) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_out = stall_cnt_q;
    assign flush_count_out  = flush_cnt_q;
`else
    assign stall_cycles_out = '0;
    assign flush_count_out  = '0;
`endif

endmodule
